// File: rtl/kernel_ledg_fader.sv
// Per-channel PWM fader between the green-LED PIO output port and the LEDG pins.
// Define KERNEL_LEDG_FADE_EN for smooth fades; left undefined, the LEDs switch instantly.
module kernel_ledg_fader #(
   parameter int NUM_LEDS = 8,
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 4096
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_LEDS-1:0] pattern_in,
   input  logic                enable,
   output logic [NUM_LEDS-1:0] led_out,
   output logic                busy
);

   logic [NUM_LEDS-1:0] pattern_q;
   logic [NUM_LEDS-1:0] pwm_on;
   logic [NUM_LEDS-1:0] led_q;
   logic                busy_q;
   logic                busy_d;

`ifdef KERNEL_LEDG_FADE_EN
   localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] MAX_LVL = '1;

   logic [PRE_W-1:0]                   pre_q, pre_d;
   logic                               step_tick;
   logic [PWM_BITS-1:0]                pwm_q, pwm_d;
   logic [NUM_LEDS-1:0][PWM_BITS-1:0]  lvl_q, lvl_d;

   always_comb begin
      step_tick = (pre_q == PRE_W'(STEP_DIV - 1));
      pre_d     = step_tick ? '0 : pre_q + 1'b1;
      // PWM period is MAX_LEVEL cycles so that a full level is on every cycle
      pwm_d     = (pwm_q == MAX_LVL - 1'b1) ? '0 : pwm_q + 1'b1;
      lvl_d     = lvl_q;
      busy_d    = 1'b0;
      pwm_on    = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         // target is all-ones when the pattern bit is set, zero otherwise
         if (step_tick) begin
            if (lvl_q[i] < {PWM_BITS{pattern_q[i]}}) begin
               lvl_d[i] = lvl_q[i] + 1'b1;
            end else if (lvl_q[i] > {PWM_BITS{pattern_q[i]}}) begin
               lvl_d[i] = lvl_q[i] - 1'b1;
            end
         end
         if (lvl_q[i] != {PWM_BITS{pattern_q[i]}}) begin
            busy_d = 1'b1;
         end
         pwm_on[i] = (lvl_q[i] > pwm_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
         pwm_q <= '0;
         lvl_q <= '0;
      end else begin
         pre_q <= pre_d;
         pwm_q <= pwm_d;
         lvl_q <= lvl_d;
      end
   end
`else
   always_comb begin
      pwm_on = pattern_q;
      busy_d = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern_q <= '0;
         led_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         pattern_q <= pattern_in;
         led_q     <= {NUM_LEDS{enable}} & pwm_on;
         busy_q    <= busy_d;
      end
   end

   assign led_out = led_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_kernel_ledg_fader.sv
// Bench for kernel_ledg_fader: cycle model from the fade rules plus directed literal checks.
// Adapts to whether KERNEL_LEDG_FADE_EN is defined for the build.
module tb_kernel_ledg_fader;

   localparam int NL   = 8;
   localparam int PB   = 4;
   localparam int SDIV = 4;
   localparam int MAXL = (1 << PB) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NL-1:0] pattern_in;
   logic          enable;
   logic [NL-1:0] led_out;
   logic          busy;

   int checks = 0;
   int errors = 0;
   logic started = 1'b0;

   kernel_ledg_fader #(.NUM_LEDS(NL), .PWM_BITS(PB), .STEP_DIV(SDIV)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pattern_in (pattern_in),
      .enable     (enable),
      .led_out    (led_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model state: cycles since reset release, brightness per channel, sampled pattern
   int            m_cyc = 0;
   int            m_lvl [NL];
   logic [NL-1:0] m_pq = '0;
   logic [NL-1:0] exp_led = '0;
   logic          exp_busy = 1'b0;

   always @(posedge clk) begin
      started <= 1'b1;
      if (!reset_n) begin
         m_cyc = 0;
         m_pq  = '0;
         for (int i = 0; i < NL; i++) m_lvl[i] = 0;
         exp_led  = '0;
         exp_busy = 1'b0;
      end else begin
`ifdef KERNEL_LEDG_FADE_EN
         exp_led  = '0;
         exp_busy = 1'b0;
         for (int i = 0; i < NL; i++) begin
            if (enable && m_lvl[i] > (m_cyc % MAXL)) exp_led[i] = 1'b1;
            if (m_lvl[i] != (m_pq[i] ? MAXL : 0)) exp_busy = 1'b1;
         end
         if ((m_cyc % SDIV) == SDIV - 1) begin
            for (int i = 0; i < NL; i++) begin
               if (m_lvl[i] < (m_pq[i] ? MAXL : 0)) m_lvl[i] = m_lvl[i] + 1;
               else if (m_lvl[i] > (m_pq[i] ? MAXL : 0)) m_lvl[i] = m_lvl[i] - 1;
            end
         end
`else
         exp_led  = enable ? m_pq : '0;
         exp_busy = 1'b0;
`endif
         m_pq  = pattern_in;
         m_cyc = m_cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_led", 32'(led_out), 32'(exp_led));
         chk("model_busy", 32'(busy), 32'(exp_busy));
      end
   end

   task automatic wait_busy_low(input int maxc);
      int k = 0;
      while (busy !== 1'b0 && k < maxc) begin
         @(negedge clk);
         k++;
      end
      chk("busy_low_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      pattern_in = '0;
      enable     = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_led", 32'(led_out), 32'h00);
      chk("reset_busy", 32'(busy), 32'd0);
      #1 reset_n = 1'b1;

      repeat (200) begin
         @(negedge clk);
         chk("idle_led", 32'(led_out), 32'h00);
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // fade up channel 0; busy follows two edges after the write
      #1 pattern_in = 8'h01;
      @(negedge clk);
      chk("busy_cycle1", 32'(busy), 32'd0);
      @(negedge clk);
`ifdef KERNEL_LEDG_FADE_EN
      chk("busy_cycle2", 32'(busy), 32'd1);
`else
      chk("busy_cycle2", 32'(busy), 32'd0);
`endif
      repeat (70) @(negedge clk);
      repeat (15) begin
         @(negedge clk);
         chk("full_led", 32'(led_out), 32'h01);
         chk("full_busy", 32'(busy), 32'd0);
      end

      // back to dark, then a reversal at level 8
      #1 pattern_in = 8'h00;
      repeat (3) @(negedge clk);
      wait_busy_low(100);
      #1 pattern_in = 8'h01;
      repeat (34) @(negedge clk);
      #1 pattern_in = 8'h00;
      repeat (3) @(negedge clk);
      wait_busy_low(60);
      repeat (30) begin
         @(negedge clk);
         chk("down_no_wrap", 32'(led_out), 32'h00);
      end

      // reset mid-fade clears everything, then the fade restarts from 0
      #1 pattern_in = 8'h01;
      repeat (20) @(negedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_led", 32'(led_out), 32'h00);
      chk("midrst_busy", 32'(busy), 32'd0);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      wait_busy_low(100);

      // all on, then gate with enable
      #1 pattern_in = 8'hFF;
      repeat (3) @(negedge clk);
      wait_busy_low(120);
      @(negedge clk);
      chk("all_on_led", 32'(led_out), 32'hFF);
      #1 enable = 1'b0;
      @(negedge clk);
      chk("disable_led", 32'(led_out), 32'h00);
      repeat (5) begin
         @(negedge clk);
         chk("disable_hold", 32'(led_out), 32'h00);
      end
      #1 enable = 1'b1;
      @(negedge clk);
      chk("reenable_led", 32'(led_out), 32'hFF);

      // pattern 0xA5: instant build shows it after two edges, fade build still full
      #1 pattern_in = 8'hA5;
      @(negedge clk);
      chk("a5_cycle1", 32'(led_out), 32'hFF);
      @(negedge clk);
`ifdef KERNEL_LEDG_FADE_EN
      chk("a5_cycle2", 32'(led_out), 32'hFF);
`else
      chk("a5_cycle2", 32'(led_out), 32'hA5);
`endif
      repeat (80) @(negedge clk);
      chk("a5_settled_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
